// File: rtl/rgb_led_pwm_pkg.sv
// Shared encodings and helpers for the RGB status-LED PWM driver.
// Gamma helper is used only when RGB_LED_GAMMA_EN is defined.
package rgb_led_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_SOLID = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_ALARM = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      S_OFF     = 2'b00,
      S_ON      = 2'b01,
      S_BLK_ON  = 2'b10,
      S_BLK_OFF = 2'b11
   } state_e;

   // Quadratic gamma: (duty*duty) >> w. Only the low w bits of the result matter.
   function automatic logic [31:0] gamma_corr(input logic [31:0] duty, input int w);
      logic [63:0] prod;
      logic [63:0] shifted;
      prod    = {32'd0, duty} * {32'd0, duty};
      shifted = prod >> w;
      return shifted[31:0];
   endfunction

endpackage

// File: rtl/rgb_led_pwm_if.sv
// Signal bundle between the timer control FSM (master) and the LED driver (slave).
interface rgb_led_pwm_if #(
   parameter int CHANNELS = 3,
   parameter int PWM_W    = 8
);
   import rgb_led_pkg::*;

   // No handshake: choice/duty/mode are level signals that the driver samples
   // only at PWM period boundaries; the master may change them at any time.
   logic [CHANNELS-1:0]       choice;
   logic [CHANNELS*PWM_W-1:0] duty;
   logic [1:0]                mode;
   logic [CHANNELS-1:0]       led_out;
   logic                      period_tick;
   state_e                    state_dbg;

   modport master (
      output choice, duty, mode,
      input  led_out, period_tick, state_dbg
   );

   modport slave (
      input  choice, duty, mode,
      output led_out, period_tick, state_dbg
   );

endinterface

// File: rtl/rgb_led_pwm_channel.sv
// One PWM channel: holds the boundary-latched duty and compares it against the shared counter.
// RGB_LED_GAMMA_EN selects gamma-corrected duty instead of linear duty.
module rgb_pwm_channel #(
   parameter int PWM_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             boundary_i,
   input  logic [PWM_W-1:0] duty_i,
   input  logic [PWM_W-1:0] cnt_i,
   output logic             on_o
);
`ifdef RGB_LED_GAMMA_EN
   import rgb_led_pkg::*;
`endif

   logic [PWM_W-1:0] duty_l_q;
   logic [PWM_W-1:0] duty_l_d;
   logic [PWM_W-1:0] duty_eff;

   always_comb begin
      duty_l_d = duty_l_q;
      if (boundary_i) duty_l_d = duty_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) duty_l_q <= '0;
      else     duty_l_q <= duty_l_d;
   end

`ifdef RGB_LED_GAMMA_EN
   assign duty_eff = PWM_W'(gamma_corr(32'(duty_l_d), PWM_W));
`else
   assign duty_eff = duty_l_d;
`endif

   // Evaluated on the next-state duty/count so the registered output lines up
   // with the counter value it belongs to. Full-on test uses the raw duty.
   assign on_o = (&duty_l_d) | (cnt_i < duty_eff);

endmodule

// File: rtl/rgb_led_pwm.sv
// Multi-channel RGB LED PWM driver with OFF/SOLID/BLINK/ALARM modes; inputs latched at period wrap.
// Define RGB_LED_GAMMA_EN to gamma-correct the per-channel duty.
module rgb_led_pwm
   import rgb_led_pkg::*;
#(
   parameter int CHANNELS      = 3,
   parameter int PWM_W         = 8,
   parameter int PRESCALE      = 4,
   parameter int BLINK_PERIODS = 64
) (
   input  logic         clk,
   input  logic         rst,
   rgb_led_pwm_if.slave bus
);

   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int BC_W  = $clog2(BLINK_PERIODS);

   localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(PRESCALE - 1);
   localparam logic [BC_W-1:0]  BLINK_LAST = BC_W'(BLINK_PERIODS - 1);
   localparam logic [BC_W-1:0]  ALARM_LAST = BC_W'(BLINK_PERIODS / 4 - 1);

   logic [PRE_W-1:0]    pre_q, pre_d;
   logic [PWM_W-1:0]    cnt_q, cnt_d;
   logic                tick;
   logic                boundary;
   logic [CHANNELS-1:0] choice_l_q, choice_l_d;
   mode_e               mode_l_q, mode_l_d;
   state_e              state_q, state_d;
   logic [BC_W-1:0]     blink_q, blink_d;
   logic [BC_W-1:0]     blink_last;
   logic [CHANNELS-1:0] ch_on;
   logic                phase_on_d;
   logic [CHANNELS-1:0] led_out_q, led_out_d;
   logic                period_tick_q;

   assign tick     = (pre_q == PRE_LAST);
   assign boundary = tick && (&cnt_q);

   always_comb begin
      pre_d = pre_q + 1'b1;
      if (tick) pre_d = '0;
      cnt_d = cnt_q;
      if (tick) cnt_d = cnt_q + 1'b1;
   end

   always_comb begin
      choice_l_d = choice_l_q;
      mode_l_d   = mode_l_q;
      if (boundary) begin
         choice_l_d = bus.choice;
         mode_l_d   = mode_e'(bus.mode);
      end
   end

   // Mode FSM; steps only on period boundaries, using the mode latched there.
   always_comb begin
      state_d    = state_q;
      blink_d    = blink_q;
      blink_last = (mode_l_d == MODE_ALARM) ? ALARM_LAST : BLINK_LAST;
      if (boundary) begin
         case (mode_l_d)
            MODE_OFF: begin
               state_d = S_OFF;
               blink_d = '0;
            end
            MODE_SOLID: begin
               state_d = S_ON;
               blink_d = '0;
            end
            default: begin
               if (state_q == S_OFF || state_q == S_ON) begin
                  state_d = S_BLK_ON;
                  blink_d = '0;
               end else if (mode_l_d != mode_l_q) begin
                  // BLINK<->ALARM: keep the current phase, restart its count.
                  blink_d = '0;
               end else if (blink_q == blink_last) begin
                  state_d = (state_q == S_BLK_ON) ? S_BLK_OFF : S_BLK_ON;
                  blink_d = '0;
               end else begin
                  blink_d = blink_q + 1'b1;
               end
            end
         endcase
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      rgb_pwm_channel #(
         .PWM_W(PWM_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .boundary_i(boundary),
         .duty_i    (bus.duty[i*PWM_W +: PWM_W]),
         .cnt_i     (cnt_d),
         .on_o      (ch_on[i])
      );
   end

   always_comb begin
      phase_on_d = (state_d == S_ON) || (state_d == S_BLK_ON);
      led_out_d  = choice_l_d & ch_on & {CHANNELS{phase_on_d}};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q         <= '0;
         cnt_q         <= '0;
         choice_l_q    <= '0;
         mode_l_q      <= MODE_OFF;
         state_q       <= S_OFF;
         blink_q       <= '0;
         led_out_q     <= '0;
         period_tick_q <= 1'b0;
      end else begin
         pre_q         <= pre_d;
         cnt_q         <= cnt_d;
         choice_l_q    <= choice_l_d;
         mode_l_q      <= mode_l_d;
         state_q       <= state_d;
         blink_q       <= blink_d;
         led_out_q     <= led_out_d;
         period_tick_q <= boundary;
      end
   end

   assign bus.led_out     = led_out_q;
   assign bus.period_tick = period_tick_q;
   assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Directed bench for rgb_led_pwm (CHANNELS=3, PWM_W=4, PRESCALE=1, BLINK_PERIODS=4, linear duty).
module tb_rgb_led_pwm;
   import rgb_led_pkg::*;

   localparam int NCH = 3;
   localparam int PW  = 4;
   localparam int PER = 16;

   logic clk;
   logic rst;
   int   total = 0;
   int   bad   = 0;

   rgb_led_pwm_if #(.CHANNELS(NCH), .PWM_W(PW)) bus ();

   rgb_led_pwm #(
      .CHANNELS     (NCH),
      .PWM_W        (PW),
      .PRESCALE     (1),
      .BLINK_PERIODS(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: time since reset, period index, and blink phase derived
   // from the period at which the current blink pattern began.
   int         k = 0;
   logic [2:0] m_choice = '0;
   logic [3:0] m_duty [NCH];
   logic [1:0] m_mode = '0;
   int         m_kind = 0;
   int         ref_p = 0;
   int         cur_p = 0;
   bit         ref_ph = 1'b0;
   bit         last_ph = 1'b0;
   bit         ph;
   logic [2:0] exp_led = '0;
   logic       exp_tick = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         k = 0;
         m_choice = '0;
         for (int i = 0; i < NCH; i++) m_duty[i] = '0;
         m_mode = '0;
         m_kind = 0;
         last_ph = 1'b0;
         exp_led = '0;
         exp_tick = 1'b0;
      end else begin
         k++;
         exp_tick = ((k % PER) == 0);
         if (exp_tick) begin
            cur_p = k / PER;
            m_choice = bus.choice;
            for (int i = 0; i < NCH; i++) m_duty[i] = bus.duty[i*PW +: PW];
            case (bus.mode)
               2'b00: begin m_kind = 0; ph = 1'b0; end
               2'b01: begin m_kind = 1; ph = 1'b1; end
               default: begin
                  if (m_kind != 2) begin
                     ref_p = cur_p;
                     ref_ph = 1'b1;
                  end else if (bus.mode != m_mode) begin
                     ref_p = cur_p;
                     ref_ph = last_ph;
                  end
                  m_kind = 2;
                  ph = ref_ph ^ ((((cur_p - ref_p) / ((bus.mode == 2'b11) ? 1 : 4)) % 2) == 1);
               end
            endcase
            m_mode = bus.mode;
            last_ph = ph;
         end
         for (int i = 0; i < NCH; i++)
            exp_led[i] = m_choice[i] && last_ph &&
                         (m_duty[i] == 4'hF || (k % PER) < int'(m_duty[i]));
      end
   end

   always @(negedge clk) begin
      total++;
      if (bus.led_out !== exp_led) begin
         bad++;
         $display("FAIL led_out @%0t: got %b expected %b", $time, bus.led_out, exp_led);
      end
      total++;
      if (bus.period_tick !== exp_tick) begin
         bad++;
         $display("FAIL period_tick @%0t: got %b expected %b", $time, bus.period_tick, exp_tick);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic sync_tick(output int waited);
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!bus.period_tick && waited < 200);
   endtask

   task automatic count_high(input int n, input int ch, output int hi);
      hi = 0;
      for (int j = 0; j < n * PER; j++) begin
         if (bus.led_out[ch]) hi++;
         @(negedge clk);
      end
   endtask

   int w;
   int hi;

   initial begin
      rst         = 1'b1;
      bus.mode    = 2'b01;
      bus.choice  = 3'b001;
      bus.duty    = {4'd0, 4'd0, 4'd5};
      repeat (3) @(negedge clk);
      rst = 1'b0;

      sync_tick(w);
      check("first_tick_latency", w, 16);
      check("state_solid", int'(bus.state_dbg), int'(S_ON));
      count_high(1, 0, hi); check("solid_duty5", hi, 5);

      bus.duty = {4'd0, 4'd0, 4'd15};
      count_high(1, 0, hi); check("duty15_pending", hi, 5);
      count_high(1, 0, hi); check("duty15_full", hi, 16);
      bus.duty = {4'd0, 4'd0, 4'd0};
      count_high(1, 0, hi); check("duty0_pending", hi, 16);
      count_high(1, 0, hi); check("duty0_off", hi, 0);

      bus.duty = {4'd0, 4'd0, 4'd5};
      count_high(1, 0, hi); check("duty5_pending", hi, 0);
      hi = 0;
      for (int j = 0; j < 3; j++) begin
         if (bus.led_out[0]) hi++;
         @(negedge clk);
      end
      bus.duty = {4'd0, 4'd0, 4'd10};
      for (int j = 3; j < PER; j++) begin
         if (bus.led_out[0]) hi++;
         @(negedge clk);
      end
      check("midperiod_keep5", hi, 5);
      count_high(1, 0, hi); check("next_period10", hi, 10);

      bus.duty   = {4'd15, 4'd15, 4'd15};
      bus.choice = 3'b111;
      bus.mode   = 2'b10;
      count_high(1, 0, hi); check("blink_pending", hi, 10);
      check("state_blk_on", int'(bus.state_dbg), int'(S_BLK_ON));
      count_high(4, 0, hi); check("blink_on4", hi, 64);
      count_high(4, 0, hi); check("blink_off4", hi, 0);
      count_high(4, 1, hi); check("blink_on4_ch1", hi, 64);

      bus.mode = 2'b11;
      count_high(1, 2, hi); check("alarm_pending_off", hi, 0);
      count_high(1, 2, hi); check("alarm_keep_phase", hi, 0);
      count_high(1, 2, hi); check("alarm_on", hi, 16);
      count_high(1, 2, hi); check("alarm_off", hi, 0);
      count_high(1, 2, hi); check("alarm_on2", hi, 16);
      count_high(1, 2, hi); check("alarm_off2", hi, 0);

      repeat (5) @(negedge clk);
      check("pre_reset_led", int'(bus.led_out), 7);
      #2 rst = 1'b1;
      #1;
      check("async_rst_led", int'(bus.led_out), 0);
      check("async_rst_tick", int'(bus.period_tick), 0);
      check("async_rst_state", int'(bus.state_dbg), int'(S_OFF));
      repeat (2) @(negedge clk);
      rst = 1'b0;

      sync_tick(w);
      check("rst_tick_latency", w, 16);
      count_high(1, 0, hi); check("restart_alarm_on", hi, 16);
      count_high(1, 0, hi); check("restart_alarm_off", hi, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
